// File: rtl/lemmings_pkg.sv
// Shared types and constants for the lemmings behavioural core.
// The bench and scoreboard import this package.
package lemmings_pkg;

    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        FALL_L = 3'd2,
        FALL_R = 3'd3,
        DIG_L  = 3'd4,
        DIG_R  = 3'd5,
        SPLAT  = 3'd6
    } state_t;

    localparam int unsigned FALL_LIMIT_DEFAULT = 20;

endpackage

// File: rtl/lemmings_fall_cnt.sv
// Saturating fall-length counter; too_long flags a fall that outlasted FALL_LIMIT.
module lemmings_fall_cnt
    import lemmings_pkg::*;
#(
    parameter int unsigned FALL_LIMIT = FALL_LIMIT_DEFAULT,
    parameter int unsigned CNT_W      = $clog2(FALL_LIMIT + 2)
) (
    input  logic clk,
    input  logic rst,
    input  logic falling_next,
    output logic too_long
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FALL_LIMIT + 1);

    logic [CNT_W-1:0] fall_cnt;

    // Counts cycles spent with aaah high; sticks at FALL_LIMIT+1 so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fall_cnt <= '0;
        end else if (!falling_next) begin
            fall_cnt <= '0;
        end else if (fall_cnt != CNT_MAX) begin
            fall_cnt <= fall_cnt + CNT_W'(1);
        end
    end

    assign too_long = (fall_cnt == CNT_MAX);

endmodule

// File: rtl/lemmings_fsm.sv
// Moore state machine for one lemming: walk, turn on bumps, fall, dig, splat.
// Outputs are pure decodes of the state register.
module lemmings_fsm
    import lemmings_pkg::*;
#(
    parameter int unsigned FALL_LIMIT = FALL_LIMIT_DEFAULT,
    parameter int unsigned CNT_W      = $clog2(FALL_LIMIT + 2)
) (
    input  logic clk,
    input  logic rst,
    input  logic bump_left,
    input  logic bump_right,
    input  logic ground,
    input  logic dig,
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic splat
);

    state_t state;
    state_t state_next;
    logic   falling_next;
    logic   too_long;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WALK_L;
        end else begin
            state <= state_next;
        end
    end

    // Priority in WALK: missing ground, then dig, then facing-side bump.
    always_comb begin
        state_next = state;
        case (state)
            WALK_L: begin
                if (!ground)        state_next = FALL_L;
                else if (dig)       state_next = DIG_L;
                else if (bump_left) state_next = WALK_R;
            end
            WALK_R: begin
                if (!ground)         state_next = FALL_R;
                else if (dig)        state_next = DIG_R;
                else if (bump_right) state_next = WALK_L;
            end
            FALL_L: begin
                if (ground) state_next = too_long ? SPLAT : WALK_L;
            end
            FALL_R: begin
                if (ground) state_next = too_long ? SPLAT : WALK_R;
            end
            DIG_L: begin
                if (!ground) state_next = FALL_L;
            end
            DIG_R: begin
                if (!ground) state_next = FALL_R;
            end
            SPLAT:   state_next = SPLAT;
            default: state_next = WALK_L;
        endcase
    end

    assign falling_next = (state_next == FALL_L) || (state_next == FALL_R);

    lemmings_fall_cnt #(
        .FALL_LIMIT(FALL_LIMIT),
        .CNT_W     (CNT_W)
    ) u_fall_cnt (
        .clk         (clk),
        .rst         (rst),
        .falling_next(falling_next),
        .too_long    (too_long)
    );

    assign walk_left  = (state == WALK_L);
    assign walk_right = (state == WALK_R);
    assign aaah       = (state == FALL_L) || (state == FALL_R);
    assign digging    = (state == DIG_L) || (state == DIG_R);
    assign splat      = (state == SPLAT);

endmodule

// File: tb/tb_lemmings_fsm.sv
// Directed bench for lemmings_fsm: walk, bump, dig, fall boundary, splat and async reset.
module tb_lemmings_fsm;
    import lemmings_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bump_left = 1'b0;
    logic bump_right = 1'b0;
    logic ground = 1'b1;
    logic dig = 1'b0;
    logic walk_left, walk_right, aaah, digging, splat;
    logic [4:0] obs;

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    assign obs = {walk_left, walk_right, aaah, digging, splat};

    lemmings_fsm #(.FALL_LIMIT(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .bump_left (bump_left),
        .bump_right(bump_right),
        .ground    (ground),
        .dig       (dig),
        .walk_left (walk_left),
        .walk_right(walk_right),
        .aaah      (aaah),
        .digging   (digging),
        .splat     (splat)
    );

    // Expected {walk_left, walk_right, aaah, digging, splat} for a named state.
    function automatic logic [4:0] exp_out(input state_t s);
        case (s)
            WALK_L:       return 5'b10000;
            WALK_R:       return 5'b01000;
            FALL_L,
            FALL_R:       return 5'b00100;
            DIG_L, DIG_R: return 5'b00010;
            SPLAT:        return 5'b00001;
            default:      return 5'b00000;
        endcase
    endfunction

    // One active edge, then settle 1 time unit (inputs may change here).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic g, input logic bl, input logic br, input logic d);
        ground = g; bump_left = bl; bump_right = br; dig = d;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        compared++;
        if (obs !== exp_out(WALK_L)) begin
            failed++; $display("FAIL reset_hold: got %b want %b", obs, exp_out(WALK_L));
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            compared++;
            if (obs !== exp_out(WALK_L)) begin
                failed++; $display("FAIL idle[%0d]: got %b want %b", i, obs, exp_out(WALK_L));
            end
        end
    endtask

    task automatic test_bumps();
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        compared++;
        if (obs !== exp_out(WALK_R)) begin
            failed++; $display("FAIL bump_turn_r: got %b want %b", obs, exp_out(WALK_R));
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        compared++;
        if (obs !== exp_out(WALK_R)) begin
            failed++; $display("FAIL bump_nonfacing: got %b want %b", obs, exp_out(WALK_R));
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        compared++;
        if (obs !== exp_out(WALK_L)) begin
            failed++; $display("FAIL bump_both: got %b want %b", obs, exp_out(WALK_L));
        end
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        compared++;
        if (obs !== exp_out(WALK_L)) begin
            failed++; $display("FAIL bump_right_in_l: got %b want %b", obs, exp_out(WALK_L));
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_dig_fall();
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        compared++;
        if (obs !== exp_out(DIG_L)) begin
            failed++; $display("FAIL dig_start: got %b want %b", obs, exp_out(DIG_L));
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        compared++;
        if (obs !== exp_out(DIG_L)) begin
            failed++; $display("FAIL dig_ignore: got %b want %b", obs, exp_out(DIG_L));
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (obs !== exp_out(FALL_L)) begin
                failed++; $display("FAIL dig_fall[%0d]: got %b want %b", i, obs, exp_out(FALL_L));
            end
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        compared++;
        if (obs !== exp_out(WALK_L)) begin
            failed++; $display("FAIL dig_land: got %b want %b", obs, exp_out(WALK_L));
        end
    endtask

    // Falls for n cycles from WALK_x (dir 0 = left, 1 = right) and lands.
    task automatic fall_and_land(input int n, input logic dir, input state_t land, input string tag);
        state_t fs;
        fs = dir ? FALL_R : FALL_L;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            tick();
            compared++;
            if (obs !== exp_out(fs)) begin
                failed++; $display("FAIL %s_fall[%0d]: got %b want %b", tag, i, obs, exp_out(fs));
            end
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        compared++;
        if (obs !== exp_out(land)) begin
            failed++; $display("FAIL %s_land: got %b want %b", tag, obs, exp_out(land));
        end
    endtask

    task automatic test_fall_boundary();
        set_in(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        compared++;
        if (obs !== exp_out(WALK_R)) begin
            failed++; $display("FAIL fb_to_r: got %b want %b", obs, exp_out(WALK_R));
        end
        fall_and_land(20, 1'b1, WALK_R, "fb20");
        fall_and_land(21, 1'b1, SPLAT, "fb21");
        for (int i = 0; i < 50; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            compared++;
            if (obs !== exp_out(SPLAT)) begin
                failed++; $display("FAIL splat_stay[%0d]: got %b want %b", i, obs, exp_out(SPLAT));
            end
        end
    endtask

    // Asserts rst between edges and checks outputs change before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        compared++;
        if (obs !== exp_out(WALK_L)) begin
            failed++; $display("FAIL %s_async: got %b want %b", tag, obs, exp_out(WALK_L));
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_priority();
        async_reset("prio");
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        compared++;
        if (obs !== exp_out(FALL_L)) begin
            failed++; $display("FAIL prio_fall: got %b want %b", obs, exp_out(FALL_L));
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        compared++;
        if (obs !== exp_out(WALK_L)) begin
            failed++; $display("FAIL prio_land: got %b want %b", obs, exp_out(WALK_L));
        end
    endtask

    task automatic test_reset_mid();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        compared++;
        if (obs !== exp_out(FALL_L)) begin
            failed++; $display("FAIL mid_fall15: got %b want %b", obs, exp_out(FALL_L));
        end
        async_reset("mid_fall");
        fall_and_land(20, 1'b0, WALK_L, "post_fall");
        fall_and_land(21, 1'b0, SPLAT, "to_splat");
        async_reset("mid_splat");
        fall_and_land(20, 1'b0, WALK_L, "post_splat");
    endtask

    initial begin
        test_reset();
        test_bumps();
        test_dig_fall();
        test_fall_boundary();
        test_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
